// File: rtl/rv_rf_wport_ctrl.sv
// rv_rf_wport_ctrl: write-port controller for the uRV register file.
//
// Shares the single register-file write port between writeback and one
// long-latency requester. It also tracks the destinations still owed by that
// requester, so decode can stall on hazards.
//
// Optional feature macro: URV_RF_CLEAR_ON_RESET_EN.
// When it is defined, an INIT state clears x1..x31 after reset. When it is
// undefined, reset goes straight to RUN and busy_o is tied low.
//
// Handshake: a long-latency result is accepted on a cycle where
// m_valid_i & m_ready_o. The producer must hold m_rd_i/m_value_i stable while
// m_valid_i is high and m_ready_o is low. Writeback is not handshaked in the
// same way: when w_stall_o is high, the core re-presents the same writeback
// on the next cycle.
module rv_rf_wport_ctrl #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  w_rd_i,
  input  logic [31:0] w_rd_value_i,
  input  logic        w_rd_store_i,
  output logic        w_stall_o,
  input  logic        m_valid_i,
  input  logic [4:0]  m_rd_i,
  input  logic [31:0] m_value_i,
  output logic        m_ready_o,
  input  logic        iss_i,
  input  logic [4:0]  iss_rd_i,
  input  logic [4:0]  d_rs1_i,
  input  logic [4:0]  d_rs2_i,
  input  logic [4:0]  d_rd_i,
  output logic        d_hazard_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_store_o,
  output logic        busy_o
);

  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [3:0] AGE_MAX = 4'd15;

  // One-hot mask of a register in pend[31:1] layout. x0 maps to an empty mask.
  function automatic logic [31:1] rd_bit(input logic [4:0] rd);
    return 31'((32'd1 << rd) >> 1);
  endfunction

`ifdef URV_RF_CLEAR_ON_RESET_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e     state_q, state_d;
  logic [4:0] idx_q, idx_d;

  // Clear-sequence state register. Reset always restarts the clear at x1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      idx_q   <= 5'd1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Walk idx through 1..31, then leave INIT after x31 has been written.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ST_INIT) begin
      idx_d = idx_q + 5'd1;
      if (idx_q == 5'd31) begin
        state_d = ST_RUN;
      end
    end
  end
`endif

  logic        buf_v_q, buf_v_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_val_q, buf_val_d;
  logic [3:0]  age_q, age_d;
  logic [31:1] pend_q, pend_d;

  logic        wreq;
  logic        force_buf;
  logic        drain;

  // Buffer and scoreboard state. Reset drops any buffered result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_v_q   <= 1'b0;
      buf_rd_q  <= 5'd0;
      buf_val_q <= 32'd0;
      age_q     <= 4'd0;
      pend_q    <= '0;
    end else begin
      buf_v_q   <= buf_v_d;
      buf_rd_q  <= buf_rd_d;
      buf_val_q <= buf_val_d;
      age_q     <= age_d;
      pend_q    <= pend_d;
    end
  end

  // Port arbitration, buffer update and hazard detection.
  always_comb begin
    w_stall_o     = 1'b0;
    m_ready_o     = 1'b0;
    d_hazard_o    = 1'b0;
    rf_rd_o       = 5'd0;
    rf_rd_value_o = 32'd0;
    rf_rd_store_o = 1'b0;
    busy_o        = 1'b0;
    buf_v_d       = buf_v_q;
    buf_rd_d      = buf_rd_q;
    buf_val_d     = buf_val_q;
    age_d         = age_q;
    pend_d        = pend_q;
    drain         = 1'b0;
    wreq          = w_rd_store_i & (w_rd_i != 5'd0);
    force_buf     = buf_v_q & (age_q >= LIMIT);

    if (rst_i) begin
      // All outputs stay at their quiet defaults while reset is held.
    end
`ifdef URV_RF_CLEAR_ON_RESET_EN
    else if (state_q == ST_INIT) begin
      busy_o        = 1'b1;
      w_stall_o     = 1'b1;
      d_hazard_o    = 1'b1;
      rf_rd_o       = idx_q;
      rf_rd_store_o = 1'b1;
    end
`endif
    else begin
      m_ready_o  = ~buf_v_q;
      // A register being drained this cycle still reads as pending.
      d_hazard_o = |(pend_q & (rd_bit(d_rs1_i) | rd_bit(d_rs2_i) | rd_bit(d_rd_i)));

      if (force_buf) begin
        // The buffered result has waited long enough, so it takes the port.
        drain     = 1'b1;
        w_stall_o = wreq;
      end else if (wreq) begin
        rf_rd_o       = w_rd_i;
        rf_rd_value_o = w_rd_value_i;
        rf_rd_store_o = 1'b1;
        if (buf_v_q && (age_q != AGE_MAX)) begin
          age_d = age_q + 4'd1;
        end
      end else if (buf_v_q) begin
        drain = 1'b1;
      end

      if (drain) begin
        // A result addressed to x0 is dropped here without a write.
        rf_rd_o       = buf_rd_q;
        rf_rd_value_o = buf_val_q;
        rf_rd_store_o = (buf_rd_q != 5'd0);
        buf_v_d       = 1'b0;
        pend_d        = pend_d & ~rd_bit(buf_rd_q);
      end

      // Accept only into an empty buffer. The drain cycle cannot also accept.
      if (m_valid_i && !buf_v_q) begin
        buf_v_d   = 1'b1;
        buf_rd_d  = m_rd_i;
        buf_val_d = m_value_i;
        age_d     = 4'd0;
      end
    end

    // The issue-side set is applied after the drain clear, so it wins a collision.
    if (!rst_i && iss_i) begin
      pend_d = pend_d | rd_bit(iss_rd_i);
    end
  end

endmodule

// File: tb/tb_rv_rf_wport_ctrl.sv
// Testbench for rv_rf_wport_ctrl.
// It runs directed scenarios, then randomized traffic. The randomized traffic
// is checked against a deadline-based reference model.
module tb_rv_rf_wport_ctrl;

  localparam int LIMIT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  w_rd_i;
  logic [31:0] w_rd_value_i;
  logic        w_rd_store_i;
  logic        w_stall_o;
  logic        m_valid_i;
  logic [4:0]  m_rd_i;
  logic [31:0] m_value_i;
  logic        m_ready_o;
  logic        iss_i;
  logic [4:0]  iss_rd_i;
  logic [4:0]  d_rs1_i, d_rs2_i, d_rd_i;
  logic        d_hazard_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        rf_rd_store_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: long-latency results accepted but not yet written, as {rd, value}.
  logic [36:0] exp_q[$];

  rv_rf_wport_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .w_rd_i(w_rd_i), .w_rd_value_i(w_rd_value_i), .w_rd_store_i(w_rd_store_i),
    .w_stall_o(w_stall_o),
    .m_valid_i(m_valid_i), .m_rd_i(m_rd_i), .m_value_i(m_value_i), .m_ready_o(m_ready_o),
    .iss_i(iss_i), .iss_rd_i(iss_rd_i),
    .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i), .d_rd_i(d_rd_i), .d_hazard_o(d_hazard_o),
    .rf_rd_o(rf_rd_o), .rf_rd_value_o(rf_rd_value_o), .rf_rd_store_o(rf_rd_store_o),
    .busy_o(busy_o)
  );

  // Clock and watchdog.
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Packed view of all outputs. Address and data are zeroed when no write occurs.
  function automatic logic [41:0] ev(input logic s, input logic [4:0] rd, input logic [31:0] v,
                                     input logic st, input logic mr, input logic hz, input logic bz);
    return {s, s ? rd : 5'd0, s ? v : 32'd0, st, mr, hz, bz};
  endfunction

  function automatic logic [41:0] outs();
    return ev(rf_rd_store_o, rf_rd_o, rf_rd_value_o, w_stall_o, m_ready_o, d_hazard_o, busy_o);
  endfunction

  // Driver tasks.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    w_rd_i = 0; w_rd_value_i = 0; w_rd_store_i = 0;
    m_valid_i = 0; m_rd_i = 0; m_value_i = 0;
    iss_i = 0; iss_rd_i = 0;
    d_rs1_i = 0; d_rs2_i = 0; d_rd_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    tick();
    rst_i = 1'b0;
`ifdef URV_RF_CLEAR_ON_RESET_EN
    repeat (31) tick();
`endif
  endtask

  task automatic test_reset();
    logic [41:0] exp;
    rst_i = 1'b1;
    w_rd_store_i = 1; w_rd_i = 3; w_rd_value_i = 32'h1234;
    m_valid_i = 1; m_rd_i = 4; iss_i = 1; iss_rd_i = 6; d_rs1_i = 6;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      exp = ev(0, 0, 0, 0, 0, 0, 0);
      n_tests++;
      if (outs() !== exp) begin
        n_fail++;
        $display("FAIL reset_hold c%0d: got %h expected %h", c, outs(), exp);
      end
      tick();
    end
    rst_i = 1'b0;
    idle_inputs();
    d_rs1_i = 6;
    @(negedge clk_i);
`ifdef URV_RF_CLEAR_ON_RESET_EN
    exp = ev(1, 1, 0, 1, 0, 1, 1);
`else
    exp = ev(0, 0, 0, 0, 1, 0, 0);
`endif
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", outs(), exp);
    end
    tick();
  endtask

`ifdef URV_RF_CLEAR_ON_RESET_EN
  task automatic test_clear();
    logic [41:0] exp;
    rst_i = 1'b1;
    idle_inputs();
    tick();
    rst_i = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk_i);
      exp = ev(1, 5'(i), 0, 1, 0, 1, 1);
      n_tests++;
      if (outs() !== exp) begin
        n_fail++;
        $display("FAIL clear_seq idx%0d: got %h expected %h", i, outs(), exp);
      end
      tick();
    end
    @(negedge clk_i);
    exp = ev(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL clear_done: got %h expected %h", outs(), exp);
    end
    // A reset in the middle of the clear restarts it at x1.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    repeat (6) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    exp = ev(1, 1, 0, 1, 0, 1, 1);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL clear_restart: got %h expected %h", outs(), exp);
    end
    tick();
  endtask
`endif

  task automatic test_idle_drain();
    logic [41:0] exp;
    do_reset();
    m_valid_i = 1; m_rd_i = 5; m_value_i = 32'hDEADBEEF;
    @(negedge clk_i);
    exp = ev(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL idle_accept: got %h expected %h", outs(), exp);
    end
    tick();
    m_valid_i = 0;
    @(negedge clk_i);
    exp = ev(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL idle_drain: got %h expected %h", outs(), exp);
    end
    tick();
    @(negedge clk_i);
    exp = ev(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL idle_after: got %h expected %h", outs(), exp);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [41:0] exp;
    do_reset();
    w_rd_store_i = 1; w_rd_i = 3;
    m_valid_i = 1; m_rd_i = 7; m_value_i = 32'h7777_0007;
    for (int c = 0; c <= LIMIT + 2; c++) begin
      w_rd_value_i = 32'h3000 + c;
      @(negedge clk_i);
      if (c == LIMIT + 1) exp = ev(1, 7, 32'h7777_0007, 1, 0, 0, 0);
      else exp = ev(1, 3, 32'h3000 + c, 0, (c == 0) || (c == LIMIT + 2), 0, 0);
      n_tests++;
      if (outs() !== exp) begin
        n_fail++;
        $display("FAIL starvation c%0d: got %h expected %h", c, outs(), exp);
      end
      tick();
      m_valid_i = 0;
    end
    idle_inputs();
  endtask

  task automatic test_hazard();
    logic [41:0] exp;
    do_reset();
    iss_i = 1; iss_rd_i = 9; d_rs2_i = 9;
    @(negedge clk_i);
    exp = ev(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL hazard_issue: got %h expected %h", outs(), exp);
    end
    tick();
    iss_i = 0;
    @(negedge clk_i);
    exp = ev(0, 0, 0, 0, 1, 1, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL hazard_set: got %h expected %h", outs(), exp);
    end
    tick();
    m_valid_i = 1; m_rd_i = 9; m_value_i = 32'h99;
    tick();
    m_valid_i = 0;
    @(negedge clk_i);
    exp = ev(1, 9, 32'h99, 0, 0, 1, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL hazard_drain: got %h expected %h", outs(), exp);
    end
    tick();
    @(negedge clk_i);
    exp = ev(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL hazard_clear: got %h expected %h", outs(), exp);
    end
    tick();
  endtask

  task automatic test_set_wins();
    logic [41:0] exp;
    do_reset();
    d_rs1_i = 9;
    iss_i = 1; iss_rd_i = 9;
    tick();
    iss_i = 0;
    m_valid_i = 1; m_rd_i = 9; m_value_i = 32'hA;
    tick();
    m_valid_i = 0;
    iss_i = 1; iss_rd_i = 9;
    @(negedge clk_i);
    exp = ev(1, 9, 32'hA, 0, 0, 1, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL setwins_drain: got %h expected %h", outs(), exp);
    end
    tick();
    iss_i = 0;
    @(negedge clk_i);
    exp = ev(0, 0, 0, 0, 1, 1, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL setwins_kept: got %h expected %h", outs(), exp);
    end
    m_valid_i = 1; m_rd_i = 9; m_value_i = 32'hB;
    tick();
    m_valid_i = 0;
    tick();
    @(negedge clk_i);
    exp = ev(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL setwins_cleared: got %h expected %h", outs(), exp);
    end
    tick();
  endtask

  task automatic test_x0();
    logic [41:0] exp;
    logic [31:0] haz_seen;
    do_reset();
    iss_i = 1; iss_rd_i = 0;
    m_valid_i = 1; m_rd_i = 0; m_value_i = 32'hBAD;
    w_rd_store_i = 1; w_rd_i = 0; w_rd_value_i = 32'h0BAD;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      exp = ev(0, 0, 0, 0, c != 1, 0, 0);
      n_tests++;
      if (outs() !== exp) begin
        n_fail++;
        $display("FAIL x0 c%0d: got %h expected %h", c, outs(), exp);
      end
      tick();
      m_valid_i = 0;
    end
    iss_i = 0;
    w_rd_store_i = 0;
    haz_seen = 0;
    for (int r = 1; r < 32; r++) begin
      d_rs1_i = 5'(r);
      @(negedge clk_i);
      haz_seen[r] = d_hazard_o;
      tick();
    end
    n_tests++;
    if (haz_seen !== 32'd0) begin
      n_fail++;
      $display("FAIL x0_pend: got %h expected %h", haz_seen, 32'd0);
    end
    d_rs1_i = 0;
    // A forced drain while writeback targets x0 must not stall writeback.
    m_valid_i = 1; m_rd_i = 11; m_value_i = 32'h1111;
    w_rd_store_i = 1; w_rd_i = 3;
    repeat (LIMIT + 1) begin
      tick();
      m_valid_i = 0;
    end
    w_rd_i = 0;
    @(negedge clk_i);
    exp = ev(1, 11, 32'h1111, 0, 0, 0, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL x0_force: got %h expected %h", outs(), exp);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_drop();
    logic [41:0] exp;
    do_reset();
    iss_i = 1; iss_rd_i = 12;
    m_valid_i = 1; m_rd_i = 12; m_value_i = 32'hC;
    w_rd_store_i = 1; w_rd_i = 2;
    tick();
    idle_inputs();
    d_rs1_i = 12;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
`ifdef URV_RF_CLEAR_ON_RESET_EN
    repeat (31) tick();
`endif
    @(negedge clk_i);
    exp = ev(0, 0, 0, 0, 1, 0, 0);
    n_tests++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL reset_drop: got %h expected %h", outs(), exp);
    end
    tick();
  endtask

  // Random traffic against a model:
  // - an accepted result is written on the first cycle with no writeback,
  //   and no later than LIMIT+1 cycles after it was accepted;
  // - a register stays pending from issue until its result is written.
  task automatic test_random();
    logic [41:0] exp;
    logic [36:0] item;
    bit [31:0]   pend_m;
    int          deadline;
    int          dens;
    bit          wreq, has, drain;
    do_reset();
    pend_m = 0;
    deadline = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      dens = ((cyc / 100) % 2 == 0) ? 95 : 40;
      w_rd_store_i = ($urandom_range(0, 99) < dens);
      w_rd_i       = 5'($urandom_range(0, 31));
      w_rd_value_i = $urandom;
      m_valid_i    = ($urandom_range(0, 2) == 0);
      m_rd_i       = 5'($urandom_range(0, 31));
      m_value_i    = $urandom;
      iss_i        = ($urandom_range(0, 3) == 0);
      iss_rd_i     = 5'($urandom_range(0, 31));
      d_rs1_i      = 5'($urandom_range(0, 31));
      d_rs2_i      = 5'($urandom_range(0, 31));
      d_rd_i       = 5'($urandom_range(0, 31));
      @(negedge clk_i);
      wreq  = w_rd_store_i && (w_rd_i != 0);
      has   = (exp_q.size() != 0);
      drain = has && ((cyc >= deadline) || !wreq);
      item  = has ? exp_q[0] : 37'd0;
      if (drain) exp = ev(item[36:32] != 0, item[36:32], item[31:0], wreq, 0, 0, 0);
      else exp = ev(wreq, w_rd_i, w_rd_value_i, 0, !has, 0, 0);
      exp[1] = pend_m[d_rs1_i] | pend_m[d_rs2_i] | pend_m[d_rd_i];
      n_tests++;
      if (outs() !== exp) begin
        n_fail++;
        $display("FAIL random c%0d: got %h expected %h", cyc, outs(), exp);
      end
      if (drain) begin
        void'(exp_q.pop_front());
        pend_m[item[36:32]] = 1'b0;
      end
      if (iss_i && iss_rd_i != 0) pend_m[iss_rd_i] = 1'b1;
      if (m_valid_i && !has) begin
        exp_q.push_back({m_rd_i, m_value_i});
        deadline = cyc + 1 + LIMIT;
      end
      tick();
    end
    idle_inputs();
  endtask

  // Test sequence and final report.
  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
`ifdef URV_RF_CLEAR_ON_RESET_EN
    test_clear();
`endif
    test_idle_drain();
    test_starvation();
    test_hazard();
    test_set_wins();
    test_x0();
    test_reset_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
